// File: rtl/gtech_reduce_pipe_if.sv
// Handshake bundle for gtech_reduce_pipe.
//   A, MODE, IN_VALID : upstream beat (operand vector, operation, valid)
//   IN_READY          : block can take a beat this cycle
//   Z, OUT_VALID      : registered reduction result and its valid
//   OUT_READY         : downstream takes Z this cycle
// master = the side driving beats in and taking results; slave = the reduction block.
interface gtech_reduce_pipe_if #(
    parameter int unsigned N = 5
) ();

    logic [N-1:0] A;
    logic [1:0]   MODE;
    logic         IN_VALID;
    logic         IN_READY;
    logic         Z;
    logic         OUT_VALID;
    logic         OUT_READY;

    modport master (
        output A,
        output MODE,
        output IN_VALID,
        output OUT_READY,
        input  IN_READY,
        input  Z,
        input  OUT_VALID
    );

    modport slave (
        input  A,
        input  MODE,
        input  IN_VALID,
        input  OUT_READY,
        output IN_READY,
        output Z,
        output OUT_VALID
    );

endinterface

// File: rtl/gtech_reduce_pipe.sv
// Pipelined N-input AND/OR/XOR/NAND reduction built as a registered radix-RADIX tree.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset; clears all stage valids and Z
//   bus  : gtech_reduce_pipe_if.slave (A, MODE, IN_VALID -> IN_READY; Z, OUT_VALID <- OUT_READY)
// Each tree level is one register stage carrying partial bits, the beat's mode and a
// valid bit. The whole pipe holds while the output is presented but not taken.
module gtech_reduce_pipe #(
    parameter int unsigned N     = 5,
    parameter int unsigned RADIX = 4
) (
    input  logic               CLK,
    input  logic               RST,
    gtech_reduce_pipe_if.slave bus
);

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    // Number of tree levels: smallest L >= 1 with RADIX**L >= N.
    function automatic int unsigned calc_levels();
        int unsigned     lv   = 0;
        longint unsigned span = 64'd1;
        while (span < 64'(N)) begin
            span = span * 64'(RADIX);
            lv   = lv + 1;
        end
        if (lv == 0) lv = 1;
        return lv;
    endfunction

    // Partial-bit count held by stage k (stage 0 is the input vector).
    function automatic int unsigned width_at(input int unsigned k);
        int unsigned w = N;
        for (int unsigned i = 0; i < k; i++) begin
            w = (w + RADIX - 1) / RADIX;
        end
        return w;
    endfunction

    localparam int unsigned LEVELS = calc_levels();

    // Identity element used to fill missing inputs of a short group.
    function automatic logic pad_bit(input logic [1:0] m);
        return !((m == MODE_OR) || (m == MODE_XOR));
    endfunction

    // One tree node; NAND reduces as AND until the root.
    function automatic logic reduce_group(input logic [RADIX-1:0] g, input logic [1:0] m);
        logic r;
        case (m)
            MODE_OR:  r = |g;
            MODE_XOR: r = ^g;
            default:  r = &g;
        endcase
        return r;
    endfunction

    logic stall_c;
    logic accept_c;

    // Handshake: hold everything while the result waits on downstream.
    always_comb begin
        stall_c  = g_stage[LEVELS].valid_q && !bus.OUT_READY;
        accept_c = bus.IN_VALID && !stall_c;
    end

    assign bus.IN_READY  = !stall_c;
    assign bus.Z         = g_stage[LEVELS].data_q[0];
    assign bus.OUT_VALID = g_stage[LEVELS].valid_q;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_stage
        localparam int unsigned WI      = width_at(k - 1);
        localparam int unsigned WO      = width_at(k);
        localparam logic        IS_ROOT = (k == LEVELS);

        logic [WI-1:0] src;
        logic [1:0]    src_mode;
        logic          src_valid;
        logic [WO-1:0] node_c;
        logic [WO-1:0] data_d;
        logic [WO-1:0] data_q;
        logic          valid_d;
        logic          valid_q;

        // Stage 1 takes the accepted beat; later stages take their predecessor.
        if (k == 1) begin : g_src_in
            assign src       = bus.A;
            assign src_mode  = bus.MODE;
            assign src_valid = accept_c;
        end else begin : g_src_prev
            assign src       = g_stage[k-1].data_q;
            assign src_mode  = g_stage[k-1].g_mode.mode_q;
            assign src_valid = g_stage[k-1].valid_q;
        end

        // One node per output bit; the last group of a level may be short and gets padded.
        for (genvar j = 0; j < WO; j++) begin : g_node
            localparam int unsigned LO = j * RADIX;
            localparam int unsigned GS = ((WI - LO) < RADIX) ? (WI - LO) : RADIX;

            logic [RADIX-1:0] grp;

            if (GS == RADIX) begin : g_full
                assign grp = src[LO +: RADIX];
            end else begin : g_pad
                assign grp = {{(RADIX - GS){pad_bit(src_mode)}}, src[LO +: GS]};
            end

            assign node_c[j] = reduce_group(grp, src_mode);
        end

        // Next-state: load from predecessor unless stalled; NAND inverts only at the root.
        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (!stall_c) begin
                data_d  = node_c ^ {WO{IS_ROOT && (src_mode == MODE_NAND)}};
                valid_d = src_valid;
            end
        end

        always_ff @(posedge CLK) begin
            if (RST) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        // Mode travels with the beat to every stage that still has a level after it.
        if (k < LEVELS) begin : g_mode
            logic [1:0] mode_d;
            logic [1:0] mode_q;

            always_comb begin
                mode_d = mode_q;
                if (!stall_c) begin
                    mode_d = src_mode;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    mode_q <= MODE_AND;
                end else begin
                    mode_q <= mode_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_gtech_reduce_pipe.sv
// Bench for gtech_reduce_pipe: default (N=5,R=4), N=1/R=2 and N=64/R=2 instances,
// directed steps plus random traffic scored against a population-count reference.
module tb_gtech_reduce_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gtech_reduce_pipe_if #(.N(5))  b5  ();
    gtech_reduce_pipe_if #(.N(1))  b1  ();
    gtech_reduce_pipe_if #(.N(64)) b64 ();

    gtech_reduce_pipe #(.N(5),  .RADIX(4)) u_d5  (.CLK(clk), .RST(rst), .bus(b5));
    gtech_reduce_pipe #(.N(1),  .RADIX(2)) u_d1  (.CLK(clk), .RST(rst), .bus(b1));
    gtech_reduce_pipe #(.N(64), .RADIX(2)) u_d64 (.CLK(clk), .RST(rst), .bus(b64));

    int n_cmp = 0;
    int n_bad = 0;

    bit q5[$];
    bit q1[$];
    bit q64[$];
    int acc5, acc1, acc64, pops5;
    bit last_acc5, last_acc1, last_acc64;

    logic [4:0] ba[8];
    logic [1:0] bm[8];
    logic       bz[8];
    int         bn;

    // Reference: result depends only on how many of the n low bits are set.
    function automatic logic ref_z(input logic [63:0] a, input int n, input logic [1:0] m);
        int ones = 0;
        for (int i = 0; i < n; i++) ones += int'(a[i]);
        case (m)
            2'b00:   return ones == n;
            2'b01:   return ones != 0;
            2'b10:   return (ones % 2) == 1;
            default: return ones != n;
        endcase
    endfunction

    function automatic logic [63:0] rnd_vec(input int n);
        logic [63:0] v;
        case ($urandom_range(0, 3))
            0:       v = '1;
            1:       v = ~(64'd1 << $urandom_range(0, n - 1));
            2:       v = '0;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes just before the edge, return 1 time unit after it.
    task automatic step();
        #1;
        if (b5.OUT_VALID && b5.OUT_READY) begin
            pops5++;
            check("z5_pending", 64'(q5.size() != 0), 1);
            if (q5.size() != 0) check("z5_seq", b5.Z, q5.pop_front());
        end
        if (b1.OUT_VALID && b1.OUT_READY) begin
            check("z1_pending", 64'(q1.size() != 0), 1);
            if (q1.size() != 0) check("z1_seq", b1.Z, q1.pop_front());
        end
        if (b64.OUT_VALID && b64.OUT_READY) begin
            check("z64_pending", 64'(q64.size() != 0), 1);
            if (q64.size() != 0) check("z64_seq", b64.Z, q64.pop_front());
        end
        last_acc5  = b5.IN_VALID && b5.IN_READY && !rst;
        last_acc1  = b1.IN_VALID && b1.IN_READY && !rst;
        last_acc64 = b64.IN_VALID && b64.IN_READY && !rst;
        if (last_acc5)  begin acc5++;  q5.push_back(ref_z(64'(b5.A), 5, b5.MODE)); end
        if (last_acc1)  begin acc1++;  q1.push_back(ref_z(64'(b1.A), 1, b1.MODE)); end
        if (last_acc64) begin acc64++; q64.push_back(ref_z(b64.A, 64, b64.MODE)); end
        if (rst) begin
            q5.delete();
            q1.delete();
            q64.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Stream bn beats back-to-back and expect bz on consecutive cycles.
    task automatic run_burst(input string tag);
        for (int i = 0; i <= bn; i++) begin
            b5.IN_VALID = (i < bn);
            if (i < bn) begin
                b5.A    = ba[i];
                b5.MODE = bm[i];
            end
            step();
            if (i >= 1) begin
                check({tag, "_v"}, b5.OUT_VALID, 1);
                check({tag, "_z"}, b5.Z, bz[i-1]);
            end
        end
        b5.IN_VALID = 1'b0;
        step();
    endtask

    initial begin
        int   idx;
        int   lat;
        logic hold_v, hold_z;

        rst = 1'b1;
        b5.A = '0;  b5.MODE = '0;  b5.IN_VALID = 1'b0;  b5.OUT_READY = 1'b1;
        b1.A = '0;  b1.MODE = '0;  b1.IN_VALID = 1'b0;  b1.OUT_READY = 1'b1;
        b64.A = '0; b64.MODE = '0; b64.IN_VALID = 1'b0; b64.OUT_READY = 1'b1;
        acc5 = 0; acc1 = 0; acc64 = 0; pops5 = 0;

        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check("rst_ov5",  b5.OUT_VALID, 0);
        check("rst_z5",   b5.Z, 0);
        check("rst_ir5",  b5.IN_READY, 1);
        check("rst_ov64", b64.OUT_VALID, 0);

        // Single all-ones AND beat: valid only on the second edge after acceptance.
        b5.A = 5'b11111; b5.MODE = 2'b00; b5.IN_VALID = 1'b1;
        step();
        b5.IN_VALID = 1'b0;
        check("one_early", b5.OUT_VALID, 0);
        step();
        check("one_v", b5.OUT_VALID, 1);
        check("one_z", b5.Z, 1);
        step();
        check("one_gone", b5.OUT_VALID, 0);

        // Mixed modes back-to-back.
        bn = 5;
        ba[0] = 5'b11111; bm[0] = 2'b00; bz[0] = 1'b1;
        ba[1] = 5'b11110; bm[1] = 2'b00; bz[1] = 1'b0;
        ba[2] = 5'b10000; bm[2] = 2'b01; bz[2] = 1'b1;
        ba[3] = 5'b10110; bm[3] = 2'b10; bz[3] = 1'b1;
        ba[4] = 5'b11111; bm[4] = 2'b11; bz[4] = 1'b0;
        run_burst("b2b");

        // Padding lanes of the short group.
        bn = 3;
        ba[0] = 5'b00000; bm[0] = 2'b01; bz[0] = 1'b0;
        ba[1] = 5'b00001; bm[1] = 2'b01; bz[1] = 1'b1;
        ba[2] = 5'b11111; bm[2] = 2'b00; bz[2] = 1'b1;
        run_burst("pad");

        // Backpressure: 8 random beats, OUT_READY low for 3 cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            ba[i] = 5'($urandom);
            bm[i] = 2'($urandom);
        end
        pops5 = 0;
        idx   = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            b5.IN_VALID  = 1'b1;
            b5.A         = ba[idx];
            b5.MODE      = bm[idx];
            b5.OUT_READY = !(c >= 4 && c < 7);
            hold_v = 1'b0;
            hold_z = 1'b0;
            if (c >= 4 && c < 7) begin
                #1;
                check("bp_ov", b5.OUT_VALID, 1);
                check("bp_ir", b5.IN_READY, 0);
                hold_v = b5.OUT_VALID;
                hold_z = b5.Z;
            end
            step();
            if (c >= 4 && c < 7) begin
                check("bp_hold_v", b5.OUT_VALID, hold_v);
                check("bp_hold_z", b5.Z, hold_z);
            end
            if (last_acc5) idx++;
        end
        check("bp_sent", idx, 8);
        b5.IN_VALID  = 1'b0;
        b5.OUT_READY = 1'b1;
        repeat (4) step();
        check("bp_pops", pops5, 8);
        check("bp_empty", q5.size(), 0);

        // Reset with two beats in flight.
        b5.IN_VALID = 1'b1; b5.A = 5'b11111; b5.MODE = 2'b00;
        step();
        b5.A = 5'b00000; b5.MODE = 2'b01;
        step();
        b5.IN_VALID  = 1'b0;
        b5.OUT_READY = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        b5.OUT_READY = 1'b1;
        check("mid_rst_ov", b5.OUT_VALID, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_rst_quiet", b5.OUT_VALID, 0);
        end
        b5.IN_VALID = 1'b1; b5.A = 5'b10101; b5.MODE = 2'b10;
        step();
        b5.IN_VALID = 1'b0;
        check("post_rst_early", b5.OUT_VALID, 0);
        step();
        check("post_rst_v", b5.OUT_VALID, 1);
        check("post_rst_z", b5.Z, 1);
        step();

        // Random traffic on all three configurations with random backpressure.
        acc5 = 0; acc1 = 0; acc64 = 0;
        b5.IN_VALID = 1'b0; b1.IN_VALID = 1'b0; b64.IN_VALID = 1'b0;
        for (int c = 0; c < 6000 && (acc5 < 1000 || acc1 < 1000 || acc64 < 1000); c++) begin
            logic [63:0] v;
            if (!b5.IN_VALID || last_acc5) begin
                v = rnd_vec(5);
                b5.A = 5'(v); b5.MODE = 2'($urandom); b5.IN_VALID = ($urandom_range(0, 4) != 0);
            end
            if (!b1.IN_VALID || last_acc1) begin
                v = rnd_vec(1);
                b1.A = 1'(v); b1.MODE = 2'($urandom); b1.IN_VALID = ($urandom_range(0, 4) != 0);
            end
            if (!b64.IN_VALID || last_acc64) begin
                v = rnd_vec(64);
                b64.A = v; b64.MODE = 2'($urandom); b64.IN_VALID = ($urandom_range(0, 4) != 0);
            end
            b5.OUT_READY  = ($urandom_range(0, 3) != 0);
            b1.OUT_READY  = ($urandom_range(0, 3) != 0);
            b64.OUT_READY = ($urandom_range(0, 3) != 0);
            step();
        end
        check("rnd_cnt5",  64'(acc5 >= 1000), 1);
        check("rnd_cnt1",  64'(acc1 >= 1000), 1);
        check("rnd_cnt64", 64'(acc64 >= 1000), 1);
        b5.IN_VALID = 1'b0;  b1.IN_VALID = 1'b0;  b64.IN_VALID = 1'b0;
        b5.OUT_READY = 1'b1; b1.OUT_READY = 1'b1; b64.OUT_READY = 1'b1;
        repeat (10) step();
        check("rnd_drain5",  q5.size(), 0);
        check("rnd_drain1",  q1.size(), 0);
        check("rnd_drain64", q64.size(), 0);

        // N=1: NAND of 1 is 0 after one edge.
        b1.A = 1'b1; b1.MODE = 2'b11; b1.IN_VALID = 1'b1;
        step();
        b1.IN_VALID = 1'b0;
        check("n1_v", b1.OUT_VALID, 1);
        check("n1_z", b1.Z, 0);

        // N=64, RADIX=2: all-ones AND after six edges.
        b64.A = '1; b64.MODE = 2'b00; b64.IN_VALID = 1'b1;
        step();
        b64.IN_VALID = 1'b0;
        lat = 1;
        while (!b64.OUT_VALID && lat < 20) begin
            step();
            lat++;
        end
        check("n64_lat", lat, 6);
        check("n64_z", b64.Z, 1);
        repeat (3) step();
        check("end_empty5",  q5.size(), 0);
        check("end_empty1",  q1.size(), 0);
        check("end_empty64", q64.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
